// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: direct-mapped, one-word-line, write-through/no-write-allocate data cache controller
module l1_dcache_ctrl #(
    parameter int LINES    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_mask,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mask,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 30 - IDX;
    localparam int CW  = $clog2(MEM_WAIT + 1);

    typedef enum logic [2:0] {IDLE, TAG, FILL, WRITE, RESP} state_t;
    state_t state, nxt;

    logic             we_q;
    logic [2:0]       mask_q;
    logic [31:0]      addr_q, wdata_q;
    logic [CW-1:0]    cnt;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      words [LINES];

    logic [IDX-1:0] idx;
    logic [TW-1:0]  addr_tag;
    logic           hit, bad, last;
    logic [4:0]     sh;
    logic [31:0]    word, lane_mask, shifted, wmerge, ld_word;

    assign idx       = addr_q[IDX+1:2];
    assign addr_tag  = addr_q[31:IDX+2];
    assign word      = words[idx];
    assign hit       = valid[idx] && tags[idx] == addr_tag;
    assign bad       = mask_q[1:0] == 2'b11 || mask_q == 3'b110;
    assign last      = cnt == CW'(MEM_WAIT - 1);
    // byte and half lanes share one shift amount for both load extraction and store merge
    assign sh        = mask_q[1:0] == 2'b00 ? {addr_q[1:0], 3'b000} :
                       mask_q[1:0] == 2'b01 ? {addr_q[1], 4'b0000} : 5'd0;
    assign lane_mask = mask_q[1:0] == 2'b00 ? 32'hFF << sh :
                       mask_q[1:0] == 2'b01 ? 32'hFFFF << sh : '1;
    assign shifted   = word >> sh;
    assign wmerge    = (word & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    assign ld_word   = mask_q[1:0] == 2'b00 ? {{24{shifted[7] & ~mask_q[2]}}, shifted[7:0]} :
                       mask_q[1:0] == 2'b01 ? {{16{shifted[15] & ~mask_q[2]}}, shifted[15:0]} : word;

    always_ff @(posedge clk)
        state <= reset ? IDLE : nxt;

    always_comb begin
        nxt       = state;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        case (state)
            IDLE: nxt = cpu_req ? TAG : IDLE;
            TAG: nxt = we_q ? WRITE : (bad || hit) ? RESP : FILL;
            FILL: begin
                mem_rd_en = 1'b1;
                mem_mask  = 3'b010;
                mem_addr  = {addr_q[31:2], 2'b00};
                nxt       = last ? RESP : FILL;
            end
            WRITE: begin
                mem_wr_en = !bad;
                mem_mask  = bad ? 3'b000 : mask_q;
                mem_addr  = bad ? '0 : addr_q;
                mem_wdata = bad ? '0 : wdata_q;
                nxt       = RESP;
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = (we_q || bad) ? '0 : ld_word;
                nxt       = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            we_q    <= cpu_we;
            mask_q  <= cpu_mask;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
        cnt <= state == FILL ? cnt + 1'b1 : '0;
        if (reset) begin
            valid    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == TAG && !we_q && !bad && hit)
                hit_cnt <= hit_cnt + 16'(hit_cnt != 16'hFFFF);
            if (state == TAG && !we_q && !bad && !hit)
                miss_cnt <= miss_cnt + 16'(miss_cnt != 16'hFFFF);
            if (state == FILL && last)
                valid[idx] <= 1'b1;
        end
    end

    // line payload is deliberately left out of reset; valid bits guard it
    always_ff @(posedge clk) begin
        if (state == FILL && last) begin
            tags[idx]  <= addr_tag;
            words[idx] <= mem_rdata;
        end
        if (state == WRITE && hit && !bad)
            words[idx] <= wmerge;
    end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb_l1_dcache_ctrl: randomized scoreboard bench; a word-residency cache model predicts data, latency and counters
module tb_l1_dcache_ctrl;
    localparam int LINES = 16;
    localparam int MW    = 2;

    logic        clk, reset, cpu_req, cpu_we, cpu_ready, mem_rd_en, mem_wr_en;
    logic [2:0]  cpu_mask, mem_mask;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          rcyc;
        logic [15:0] hits;
        logic [15:0] misses;
        int          rd;
        int          wr;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem [1024];
    logic [31:0] mm [1024];
    logic [2:0]  masks [8];
    int          resident [LINES];
    logic [15:0] ehit = 0, emiss = 0;
    int erd = 0, ewr = 0, nops = 0, cyc = 0, checks = 0, errors = 0;
    int rd_seen = 0, wr_seen = 0, both_seen = 0, rd_fmt_bad = 0;

    l1_dcache_ctrl #(.LINES(LINES), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mask(cpu_mask),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    function automatic logic [31:0] seed(input int i);
        return i == 64 ? 32'hA1B2C3D4 : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] w, input logic [2:0] m,
                                          input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (m[1:0] == 2'b00) r[8*a +: 8] = d[7:0];
        else if (m[1:0] == 2'b01) r[16*a[1] +: 16] = d[15:0];
        else r = d;
        return r;
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] m, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (m)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s op%0d: got %h want %h", name, id, act, want);
        end
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < LINES; i++) resident[i] = -1;
        ehit  = 0;
        emiss = 0;
    endfunction

    // expectation is computed from the rules: which word sits at each index, and memory contents
    task automatic push(input logic we, input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input bit use_lit, input logic [31:0] lit, output int id);
        exp_t e;
        int   w, i, lat;
        bit   inv;
        w   = int'(a[11:2]);
        i   = w % LINES;
        inv = m == 3'b011 || m == 3'b110 || m == 3'b111;
        e.rdata = 0;
        if (we) begin
            lat = 3;
            if (!inv) begin
                mm[w] = apply(mm[w], m, a[1:0], wd);
                ewr++;
            end
        end else if (inv) begin
            lat = 2;
        end else begin
            if (resident[i] == w) begin
                lat = 2;
                if (ehit != 16'hFFFF) ehit++;
            end else begin
                lat = 2 + MW;
                if (emiss != 16'hFFFF) emiss++;
                resident[i] = w;
                erd += MW;
            end
            e.rdata = fmt(mm[w], m, a[1:0]);
        end
        if (use_lit) e.rdata = lit;
        e.id = nops++;
        e.rcyc = cyc + lat;
        e.hits = ehit;
        e.misses = emiss;
        e.rd = erd;
        e.wr = ewr;
        id = e.id;
        sbq.push_back(e);
    endtask

    task automatic wait_ready(input int id);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cpu_ready && k < 40);
        cpu_req = 1'b0;
        if (!cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL timeout op%0d: no cpu_ready in 40 cycles, want completion", id);
            sbq.delete();
        end
    endtask

    task automatic req(input logic we, input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                       input bit use_lit, input logic [31:0] lit);
        int id;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_mask = m;
        cpu_addr = a;
        cpu_wdata = wd;
        push(we, m, a, wd, use_lit, lit, id);
        wait_ready(id);
    endtask

    task automatic rand_op();
        int k, w;
        logic we;
        logic [2:0] m;
        we = $urandom_range(0, 2) == 0;
        k  = $urandom_range(0, 15);
        m  = masks[k < 13 ? (we ? k % 3 : k % 5) : 5 + k - 13];
        w  = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 159)) : int'($urandom_range(0, 31));
        req(we, m, 32'(w * 4) + 32'($urandom_range(0, 3)), $urandom, 1'b0, 32'd0);
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        int k = 0, id;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_mask = 3'b010;
        cpu_addr = a;
        cpu_wdata = 0;
        while (!mem_rd_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("fill_started", -1, 32'(mem_rd_en), 32'd1);
        reset = 1'b1;
        erd += 1;
        @(negedge clk);
        chk("rst_fill_rd_en", -1, 32'(mem_rd_en), 32'd0);
        chk("rst_fill_ready", -1, 32'(cpu_ready), 32'd0);
        chk("rst_fill_miss", -1, 32'(miss_cnt), 32'd0);
        clear_model();
        reset = 1'b0;
        push(1'b0, 3'b010, a, 32'd0, 1'b0, 32'd0, id);
        wait_ready(id);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = seed(i);
        forever begin
            @(negedge clk);
            if (mem_wr_en)
                mem[mem_addr[11:2]] = apply(mem[mem_addr[11:2]], mem_mask, mem_addr[1:0], mem_wdata);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            rd_seen += int'(mem_rd_en);
            wr_seen += int'(mem_wr_en);
            if (mem_rd_en && mem_wr_en) both_seen++;
            if (mem_rd_en && (mem_addr[1:0] != 2'b00 || mem_mask != 3'b010)) rd_fmt_bad++;
            if (cpu_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready cycle %0d: got cpu_ready=1 want 0", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", e.id, cpu_rdata, e.rdata);
                    chk("latency", e.id, 32'(cyc), 32'(e.rcyc));
                    chk("hit_cnt", e.id, 32'(hit_cnt), 32'(e.hits));
                    chk("miss_cnt", e.id, 32'(miss_cnt), 32'(e.misses));
                    chk("rd_cycles", e.id, 32'(rd_seen), 32'(e.rd));
                    chk("wr_cycles", e.id, 32'(wr_seen), 32'(e.wr));
                    chk("mem_idle", e.id, mem_addr | mem_wdata | 32'(mem_mask), 32'd0);
                    chk("strobe_shape", e.id, 32'(both_seen + rd_fmt_bad), 32'd0);
                end
            end
        end
    end

    initial begin
        int diff = 0;
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_mask = 3'b000;
        cpu_addr = 0;
        cpu_wdata = 0;
        masks = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 1024; i++) mm[i] = seed(i);
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_ready", -1, 32'(cpu_ready), 32'd0);
        chk("rst_rd_en", -1, 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", -1, 32'(mem_wr_en), 32'd0);
        chk("rst_rdata", -1, cpu_rdata, 32'd0);
        chk("rst_mem_addr", -1, mem_addr, 32'd0);
        chk("rst_hit", -1, 32'(hit_cnt), 32'd0);
        chk("rst_miss", -1, 32'(miss_cnt), 32'd0);
        reset = 1'b0;
        req(1'b0, 3'b010, 32'h100, 0, 1'b1, 32'hA1B2C3D4);
        req(1'b0, 3'b010, 32'h100, 0, 1'b1, 32'hA1B2C3D4);
        req(1'b0, 3'b000, 32'h103, 0, 1'b1, 32'hFFFFFFA1);
        req(1'b0, 3'b100, 32'h103, 0, 1'b1, 32'h000000A1);
        req(1'b0, 3'b001, 32'h102, 0, 1'b1, 32'hFFFFA1B2);
        req(1'b0, 3'b101, 32'h100, 0, 1'b1, 32'h0000C3D4);
        req(1'b1, 3'b000, 32'h101, 32'h55, 1'b0, 0);
        req(1'b0, 3'b010, 32'h100, 0, 1'b1, 32'hA1B255D4);
        req(1'b1, 3'b010, 32'h200, 32'h12345678, 1'b0, 0);
        req(1'b0, 3'b010, 32'h200, 0, 1'b1, 32'h12345678);
        req(1'b0, 3'b010, 32'h200 + 4 * LINES, 0, 1'b0, 0);
        req(1'b0, 3'b010, 32'h200, 0, 1'b1, 32'h12345678);
        req(1'b1, 3'b111, 32'h100, 32'hDEADBEEF, 1'b0, 0);
        req(1'b0, 3'b011, 32'h100, 0, 1'b1, 32'd0);
        for (int n = 0; n < 300; n++) rand_op();
        reset_mid_fill(32'h300);
        for (int n = 0; n < 40; n++) rand_op();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 1024; i++) if (mem[i] !== mm[i]) diff++;
        chk("mem_final_diffs", -1, 32'(diff), 32'd0);
        chk("sb_drained", -1, 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
